// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy width, stage states,
// and WB control-field bit positions used when packing payloads.
package pipe_pkg;

  localparam int OCC_W = 2;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MAIN,
    ST_FULL
  } pipe_state_e;

  function automatic logic [OCC_W-1:0] occ_of(
    input pipe_state_e s
  );
    logic [OCC_W-1:0] n;
    n = '0;
    unique case (s)
      ST_EMPTY: n = 2'd0;
      ST_MAIN:  n = 2'd1;
      ST_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data holding register; clear wins over load and
// returns the payload to RST_VAL.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= RST_VAL;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= RST_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage with optional 2-entry skid.
// `define PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter bit                SKID_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_valid_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              up_ready_o,
  output logic              dn_valid_o,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              dn_ready_i,
  input  logic              flush_i,
  output logic [OCC_W-1:0]  occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  pipe_state_e state_q, state_d;

  logic              up_fire;
  logic              dn_fire;
  logic              can_take;
  logic              main_load;
  logic              main_clr;
  logic              skid_load;
  logic              skid_clr;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  // With the skid, ready comes straight from a flop (skid free).
  assign can_take = SKID_EN ? ~skid_valid
                            : (~main_valid | dn_ready_i);

  assign up_ready_o = rst_i & ~flush_i & can_take;
  assign up_fire    = up_valid_i & up_ready_o;
  assign dn_fire    = main_valid & dn_ready_i;

  assign dn_valid_o  = main_valid;
  assign dn_data_o   = main_q;
  assign occupancy_o = occ_of(state_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = up_data_i;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_fire) begin
            main_load = 1'b1;
            state_d   = ST_MAIN;
          end
        end
        ST_MAIN: begin
          // Accept-without-drain only reachable when SKID_EN=1.
          unique case (1'b1)
            up_fire && !dn_fire: begin
              skid_load = 1'b1;
              state_d   = ST_FULL;
            end
            up_fire && dn_fire: begin
              main_load = 1'b1;
            end
            !up_fire && dn_fire: begin
              main_clr = 1'b1;
              state_d  = ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (dn_fire) begin
            main_load = 1'b1;
            main_d    = skid_q;
            skid_clr  = 1'b1;
            state_d   = ST_MAIN;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk   (clk_i),
    .rst_n (rst_i),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_skid_entry #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk   (clk_i),
    .rst_n (rst_i),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (up_data_i),
    .valid (skid_valid),
    .q     (skid_q)
  );

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (main_valid && !dn_ready_i && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (!main_valid && dn_ready_i && !(&bubble_cnt_o))
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: directed scenarios plus random traffic
// against a FIFO-of-two reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        up_valid_i = 1'b0;
  logic [31:0] up_data_i = '0;
  logic        dn_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        up_ready_o;
  logic        dn_valid_o;
  logic [31:0] dn_data_o;
  logic [1:0]  occupancy_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] bubble_cnt_o;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  int m_stall = 0;
  int m_bubble = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .up_valid_i  (up_valid_i),
    .up_data_i   (up_data_i),
    .up_ready_o  (up_ready_o),
    .dn_valid_o  (dn_valid_o),
    .dn_data_o   (dn_data_o),
    .dn_ready_i  (dn_ready_i),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts at a negedge, ends at the next negedge.
  task automatic step(input logic uv, input logic [31:0] ud,
                      input logic dr, input logic fl);
    logic rdy;
    up_valid_i = uv;
    up_data_i  = ud;
    dn_ready_i = dr;
    flush_i    = fl;
    #1;
    rdy = (q.size() < 2) && !fl;
    check("up_ready", 32'(up_ready_o), 32'(rdy));
    check("dn_valid", 32'(dn_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) check("dn_data", dn_data_o, q[0]);
    check("occupancy", 32'(occupancy_o), 32'(q.size()));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", stall_cnt_o, 32'(m_stall));
    check("bubble_cnt", bubble_cnt_o, 32'(m_bubble));
`endif
    if (q.size() != 0 && !dr) m_stall++;
    if (q.size() == 0 && dr) m_bubble++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() != 0 && dr) void'(q.pop_front());
      if (uv && rdy) q.push_back(ud);
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    up_valid_i = 1'b0;
    dn_ready_i = 1'b0;
    flush_i    = 1'b0;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check("ar_valid", 32'(dn_valid_o), 32'd0);
    check("ar_data", dn_data_o, 32'd0);
    check("ar_occ", 32'(occupancy_o), 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    check("ar_stall", stall_cnt_o, 32'd0);
`endif
    q.delete();
    m_stall = 0;
    m_bubble = 0;
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  initial begin
    #1;
    rst_i      = 1'b0;
    up_valid_i = 1'b1;
    up_data_i  = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(dn_valid_o), 32'd0);
    check("rst_data", dn_data_o, 32'd0);
    check("rst_occ", 32'(occupancy_o), 32'd0);
    rst_i = 1'b1;
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // streaming
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    step(1'b1, 32'h3, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // back-pressure
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // flush while full
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    check("flush_data", dn_data_o, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // async reset while full
    step(1'b1, 32'h7, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b0, 1'b0);
    check("pre_ar_occ", 32'(occupancy_o), 32'd2);
    async_reset();

    // stall/bubble sequence
    step(1'b1, 32'h55, 1'b0, 1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    check("stall5", stall_cnt_o, 32'd5);
    check("bubble3", bubble_cnt_o, 32'd3);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
